// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ datapath stages.
// Holds the icode constants, architectural status codes and the
// run/halt state encoding used by memory_stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem.sv
// Byte-addressed data memory for the SEQ memory stage.
// Ports:
//   clk   - write clock
//   we    - write enable; 8 bytes at addr..addr+7 written on the rising edge
//   addr  - byte address (little-endian, unaligned allowed)
//   wdata - 64-bit write data
//   rdata - 64-bit combinational read of addr..addr+7
// The caller guarantees addr <= MEM_BYTES-8 whenever the data is used.
module data_mem #(
  parameter int unsigned MEM_BYTES = 8192,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem_q [MEM_BYTES];

  // Out-of-array byte indices only arise for faulting addresses, whose
  // read data is discarded upstream; they read as zero here.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (32'(addr + AW'(i)) < MEM_BYTES) begin
        rdata[8*i +: 8] = mem_q[addr + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem_q[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage.
// Selects the data-memory address/data from icode, performs 8-byte
// little-endian loads and stores, folds fetch and memory faults into the
// architectural status and freezes stores once a non-AOK status commits.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   icode       - instruction code from fetch
//   valA/valE/valP - decode operand, ALU result, incremented PC
//   instr_valid - fetch decoded a legal instruction
//   imem_error  - fetch address fault
//   valM        - load data (0 when no valid load)
//   dmem_error  - data access out of range
//   stat        - status: AOK=1, HLT=2, ADR=3, INS=4
//   halted      - run/halt machine is halted
module memory_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_we;
  logic [63:0] rdata;
  stat_e       live_stat;
  state_e      state_q, state_d;
  stat_e       stat_q, stat_d;

  always_comb begin
    mem_addr  = '0;
    mem_data  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (icode)
      I_RMMOVQ: begin mem_addr = valE; mem_data = valA; mem_write = 1'b1; end
      I_MRMOVQ: begin mem_addr = valE; mem_read = 1'b1; end
      I_CALL:   begin mem_addr = valE; mem_data = valP; mem_write = 1'b1; end
      I_PUSHQ:  begin mem_addr = valE; mem_data = valA; mem_write = 1'b1; end
      I_RET:    begin mem_addr = valA; mem_read = 1'b1; end
      I_POPQ:   begin mem_addr = valA; mem_read = 1'b1; end
      default:  ;
    endcase
  end

  // Full 64-bit compare against the last legal start address avoids any
  // wrap-around of mem_addr+7 near 2^64.
  assign dmem_error = (mem_read | mem_write) && (mem_addr > ADDR_MAX);

  always_comb begin
    if (imem_error || dmem_error) live_stat = STAT_ADR;
    else if (!instr_valid)        live_stat = STAT_INS;
    else if (icode == I_HALT)     live_stat = STAT_HLT;
    else                          live_stat = STAT_AOK;
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    if (state_q == S_RUN && live_stat != STAT_AOK) begin
      state_d = S_HALTED;
      stat_d  = live_stat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  assign mem_we = mem_write && !dmem_error && (live_stat == STAT_AOK)
                  && (state_q == S_RUN) && !reset;

  data_mem #(.MEM_BYTES(MEM_BYTES)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr[AW-1:0]),
    .wdata (mem_data),
    .rdata (rdata)
  );

  assign valM   = (mem_read && !dmem_error) ? rdata : '0;
  assign stat   = (state_q == S_HALTED) ? stat_q : live_stat;
  assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import y86_pkg::*;

  localparam int unsigned MB = 8192;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        instr_valid, imem_error;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic        halted;

  memory_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .icode(icode), .valA(valA), .valE(valE),
    .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
    .valM(valM), .dmem_error(dmem_error), .stat(stat), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // reference model state
  logic [7:0] m_mem   [MB];
  bit         m_known [MB];
  bit         m_halted;
  int         m_stat;

  logic [63:0] last_valM;
  logic [2:0]  last_stat;
  logic        last_derr, last_halted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One processor cycle: drive inputs, compare combinational outputs to the
  // model, then clock the edge and advance the model.
  task automatic step(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                      input logic [63:0] p, input bit iv, input bit ie, input bit rst,
                      input bit chk);
    bit rd, wr, derr, all_known;
    logic [63:0] addr, data, exp_m;
    int live, idx;
    icode = ic; valA = a; valE = e; valP = p;
    instr_valid = iv; imem_error = ie; reset = rst;
    rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'hA) addr = e;
    else if (ic == 4'h9 || ic == 4'hB) addr = a;
    else addr = 64'd0;
    data = (ic == 4'h8) ? p : a;
    derr = (rd || wr) && (addr > 64'(MB - 8));
    if (ie || derr) live = 3;
    else if (!iv) live = 4;
    else if (ic == 4'h0) live = 2;
    else live = 1;
    exp_m = 64'd0;
    all_known = 1;
    if (rd && !derr) begin
      for (int k = 0; k < 8; k++) begin
        idx = int'(addr[31:0]) + k;
        if (!m_known[idx]) all_known = 0;
        exp_m[8*k +: 8] = m_mem[idx];
      end
    end
    #1;
    last_valM = valM; last_stat = stat; last_derr = dmem_error; last_halted = halted;
    if (chk) begin
      if (all_known) check("valM", valM, exp_m);
      check("dmem_error", 64'(dmem_error), 64'(derr));
      check("stat", 64'(stat), 64'(m_halted ? m_stat : live));
      check("halted", 64'(halted), 64'(m_halted));
    end
    @(posedge clk);
    if (wr && !derr && live == 1 && !m_halted && !rst) begin
      for (int k = 0; k < 8; k++) begin
        idx = int'(addr[31:0]) + k;
        m_mem[idx] = data[8*k +: 8];
        m_known[idx] = 1;
      end
    end
    if (rst) begin
      m_halted = 0; m_stat = 1;
    end else if (!m_halted && live != 1) begin
      m_halted = 1; m_stat = live;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel < 7) return 64'h100 + 64'($urandom_range(0, 63));
    else if (sel < 9) return 64'(MB - 16) + 64'($urandom_range(0, 15));
    else return {$urandom, $urandom};
  endfunction

  initial begin
    logic [3:0] ic;
    bit iv, ie, rs;
    for (int i = 0; i < MB; i++) m_known[i] = 0;
    m_halted = 0; m_stat = 1;
    icode = I_NOP; valA = '0; valE = '0; valP = '0;
    instr_valid = 1; imem_error = 0; reset = 1;

    step(I_NOP, 0, 0, 0, 1, 0, 1, 0);
    step(I_NOP, 0, 0, 0, 1, 0, 1, 1);
    step(I_NOP, 0, 0, 0, 1, 0, 0, 1);
    check("reset_stat", 64'(last_stat), 64'(STAT_AOK));
    check("reset_halted", 64'(last_halted), 64'd0);

    // store then load
    step(I_RMMOVQ, 64'h0123456789ABCDEF, 64'h100, 0, 1, 0, 0, 1);
    step(I_MRMOVQ, 0, 64'h100, 0, 1, 0, 0, 1);
    check("load_value", last_valM, 64'h0123456789ABCDEF);
    check("load_lsbyte", 64'(last_valM[7:0]), 64'hEF);

    // call / ret
    step(I_CALL, 0, 64'h1F8, 64'h40, 1, 0, 0, 1);
    step(I_RET, 64'h1F8, 0, 0, 1, 0, 0, 1);
    check("ret_valM", last_valM, 64'h40);
    check("ret_stat", 64'(last_stat), 64'(STAT_AOK));

    // address fault on a store; top legal word keeps its prior contents
    step(I_RMMOVQ, 64'hCAFEF00DDEADBEEF, 64'(MB - 8), 0, 1, 0, 0, 1);
    step(I_RMMOVQ, 64'h1111111111111111, 64'(MB - 7), 0, 1, 0, 0, 1);
    check("fault_derr", 64'(last_derr), 64'd1);
    check("fault_stat", 64'(last_stat), 64'(STAT_ADR));
    step(I_MRMOVQ, 0, 64'(MB - 8), 0, 1, 0, 0, 1);
    check("fault_nowrite", last_valM, 64'hCAFEF00DDEADBEEF);
    check("fault_halted", 64'(last_halted), 64'd1);
    step(I_NOP, 0, 0, 0, 1, 0, 1, 1);
    step(I_MRMOVQ, 0, 64'hFFFFFFFFFFFFFFFC, 0, 1, 0, 0, 1);
    check("wrap_stat", 64'(last_stat), 64'(STAT_ADR));
    check("wrap_valM", last_valM, 64'd0);
    step(I_NOP, 0, 0, 0, 1, 0, 1, 1);

    // halt latch, then store while halted is ignored
    step(I_HALT, 0, 0, 0, 1, 0, 0, 1);
    check("halt_stat", 64'(last_stat), 64'(STAT_HLT));
    step(I_PUSHQ, 64'h5555AAAA5555AAAA, 64'h100, 0, 1, 0, 0, 1);
    check("halt_halted", 64'(last_halted), 64'd1);
    check("halt_stat_hold", 64'(last_stat), 64'(STAT_HLT));
    step(I_MRMOVQ, 0, 64'h100, 0, 1, 0, 0, 1);
    check("halt_nowrite", last_valM, 64'h0123456789ABCDEF);
    step(I_NOP, 0, 0, 0, 1, 0, 1, 1);

    // priority, then reset with a store present
    step(I_NOP, 0, 0, 0, 0, 1, 0, 1);
    check("prio_adr", 64'(last_stat), 64'(STAT_ADR));
    step(I_RMMOVQ, 64'h7777777777777777, 64'h100, 0, 1, 0, 1, 1);
    step(I_MRMOVQ, 0, 64'h100, 0, 1, 0, 0, 1);
    check("rst_halted", 64'(last_halted), 64'd0);
    check("rst_stat", 64'(last_stat), 64'(STAT_AOK));
    check("rst_nowrite", last_valM, 64'h0123456789ABCDEF);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      ic = 4'($urandom_range(0, 11));
      if (ic == I_HALT && $urandom_range(0, 3) != 0) ic = I_NOP;
      iv = ($urandom_range(0, 39) != 0);
      ie = ($urandom_range(0, 59) == 0);
      rs = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      step(ic, rand_addr(), rand_addr(), {$urandom, $urandom}, iv, ie, rs, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the SEQ Y86-64 processor, directly upstream of `write_back`. It computes the data-memory address and write data from `icode`, holds the byte-addressed data memory, and produces `valM`, which `write_back` consumes alongside `valE`. It also folds fetch and memory faults into the architectural status code. A two-state run/halt machine freezes memory writes once a non-AOK status has been committed.

## Interface
Parameters:
- `MEM_BYTES`, 8192 — data memory size in bytes; must be ≥ 8.

Ports:
- `clk`  in  1  — processor clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `icode`  in  4  — instruction code from fetch.
- `valA`  in  64  — register operand A from decode.
- `valE`  in  64  — ALU result from execute.
- `valP`  in  64  — incremented PC from fetch.
- `instr_valid`  in  1  — fetch decoded a legal icode/ifun.
- `imem_error`  in  1  — fetch address fault.
- `valM`  out  64  — data read from memory; goes to `write_back`.
- `dmem_error`  out  1  — data access is out of range.
- `stat`  out  3  — status code: AOK=1, HLT=2, ADR=3, INS=4.
- `halted`  out  1  — run/halt machine is in HALTED.

## Operation
Address and data selection, combinational:
- `mem_addr` = `valE` for rmmovq (4), mrmovq (5), call (8), pushq (A).
- `mem_addr` = `valA` for ret (9), popq (B).
- `mem_addr` = 0 otherwise.
- `mem_data` = `valA` for rmmovq and pushq; `valP` for call.
- `mem_read` = mrmovq | ret | popq.
- `mem_write` = rmmovq | call | pushq.

Memory access:
- All accesses are 8 bytes wide and little-endian. Unaligned addresses are legal.
- `dmem_error` = (`mem_read` | `mem_write`) & (`mem_addr` > MEM_BYTES−8), compared as unsigned 64-bit. This also catches addresses near 2^64 without wrap-around.
- `valM` = bytes [`mem_addr` .. `mem_addr`+7] when `mem_read` & !`dmem_error`; otherwise 0.

Status, in priority order:
- ADR if `imem_error` | `dmem_error`.
- else INS if !`instr_valid`.
- else HLT if `icode`==0.
- else AOK.

State machine:
- States are RUN and HALTED.
- In RUN, `stat` shows the live status.
- RUN → HALTED on a rising edge where the live status ≠ AOK and `reset`=0. The live status is captured into `stat_q` on that edge.
- In HALTED, `stat` = `stat_q` and `halted`=1.
- HALTED persists until `reset`.

Write enable:
- Memory is written at the rising edge only when `mem_write` & !`dmem_error` & live status==AOK & state==RUN & !`reset`.
- A faulting store writes nothing, including partial bytes.

Reset:
- State = RUN, `stat_q` = AOK, `halted`=0.
- Memory contents are not cleared by reset.

## Timing
- `valM`, `dmem_error` and `stat` (in RUN) are combinational from the inputs, with zero-cycle latency, matching SEQ.
- A write takes effect at the rising edge and is visible to reads in the following cycle.
- A read in the same cycle as a write to the same address returns the old data.
- Reset asserted mid-operation: the write on that edge is suppressed, and the next cycle is in RUN with AOK.
- Simultaneous `imem_error` and illegal instruction: ADR wins.
- Simultaneous `dmem_error` and `icode`=halt cannot occur, because halt performs no access.
- The first non-AOK cycle shows its status combinationally; the status is latched at the end of that cycle.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants `I_HALT`..`I_POPQ`.
  - status codes `STAT_AOK`, `STAT_HLT`, `STAT_ADR`, `STAT_INS`.
  - state encoding `S_RUN`, `S_HALTED`.
- Sub-module `data_mem(MEM_BYTES)` contains the byte array with an 8-byte combinational read port and an 8-byte synchronous write port (`we`, `addr`, `wdata`).
- `memory_stage` contains the selection logic, the status logic and the FSM.

## Test plan
- Store/load: rmmovq with `valE`=0x100, `valA`=0x0123456789ABCDEF. Next cycle, mrmovq with `valE`=0x100 → `valM`=0x0123456789ABCDEF. mrmovq with `valE`=0x100 reads byte 0xEF.
- Call/ret: call with `valE`=0x1F8, `valP`=0x40. Next cycle, ret with `valA`=0x1F8 → `valM`=0x40, `stat`=AOK.
- Address fault:
  - rmmovq with `valE`=MEM_BYTES−7 → `dmem_error`=1, `stat`=3, no write. A later read of MEM_BYTES−8 returns its prior contents.
  - `valE`=0xFFFFFFFFFFFFFFFC → ADR.
- Halt latch: `icode`=0 → `stat`=2. After the edge, `halted`=1. A subsequent pushq with AOK inputs writes nothing and `stat` stays 2.
- Priority and reset: `imem_error`=1 with `instr_valid`=0 → `stat`=3. While HALTED, pulse `reset` with rmmovq present → no write; next cycle `halted`=0, `stat`=AOK.
